sensor_sample_scheduler: RTL
============================

SENSOR_SAMPLE_SCHEDULER -- requirements
Module: sensor_sample_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of sensor requesters sharing one input buffer.
REQ-002 SHALL have parameter DATA_W, default 8, sensor sample width.
REQ-003 SHALL have parameter PERIOD_W, default 16, width of sample period setting.
REQ-004 SHALL have parameter TIMEOUT, default 4, max cycles waiting for buffer valid.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  permits new sampling rounds.
REQ-008 sample_period  input  PERIOD_W  tick interval minus one, in cycles.
REQ-009 ch_req  input  NUM_CH  per-channel sample request, level.
REQ-010 ch_data  input  NUM_CH*DATA_W  packed sensor data, channel i at bits [i*DATA_W +: DATA_W].
REQ-011 ch_grant  output  NUM_CH  one-hot grant, high only in READ.
REQ-012 buf_read_enable  output  1  load strobe to input buffer.
REQ-013 buf_sensor_input  output  DATA_W  data of granted channel, to input buffer.
REQ-014 buf_output  input  DATA_W  input buffer data.
REQ-015 buf_valid  input  1  input buffer valid flag.
REQ-016 out_data  output  DATA_W  captured sample.
REQ-017 out_ch  output  clog2(NUM_CH)  channel index of out_data.
REQ-018 out_valid  output  1  sample available downstream.
REQ-019 out_ready  input  1  downstream accept.
REQ-020 timeout_err  output  1  sticky: buffer failed to return valid.
REQ-021 overrun_cnt  output  8  saturating count of ticks lost while busy.

Function
REQ-022 Tick counter: when enable=1 and count==0, tick asserts one cycle and count reloads sample_period; else count decrements; tick rate = sample_period+1 cycles (0 => every cycle).
REQ-023 enable=0: count held at 0, no tick; in-flight transaction SHALL complete normally.
REQ-024 FSM states IDLE, READ, CAPTURE, OUT; reset state IDLE.
REQ-025 IDLE: on tick with |ch_req, latch round-robin winner into grant register, go READ; tick with no request: stay IDLE, no count change.
REQ-026 Round-robin: search starts at channel after last granted; last-granted resets to NUM_CH-1 so channel 0 wins first.
REQ-027 READ (exactly one cycle): buf_read_enable=1, ch_grant=one-hot winner, buf_sensor_input=ch_data of winner; next state CAPTURE.
REQ-028 buf_sensor_input SHALL be 0 outside READ.
REQ-029 CAPTURE: on buf_valid=1 latch buf_output to out_data and winner index to out_ch, go OUT.
REQ-030 CAPTURE: if buf_valid not seen within TIMEOUT cycles, set timeout_err, go IDLE, out_valid stays 0.
REQ-031 OUT: out_valid=1, out_data/out_ch stable until out_ready=1; on out_valid&&out_ready go IDLE next cycle.
REQ-032 Nominal latency: tick in cycle T -> READ T+1 -> buf_valid T+2 -> out_valid T+3.
REQ-033 Tick while FSM not IDLE: overrun_cnt increments, saturating at 255; tick is dropped, not queued.
REQ-034 ch_req deasserted after grant latched SHALL not abort the transaction.
REQ-035 timeout_err and overrun_cnt clear only on reset.

Reset
REQ-036 On reset: state IDLE, count 0, last-granted NUM_CH-1, ch_grant 0, buf_read_enable 0, buf_sensor_input 0, out_data 0, out_ch 0, out_valid 0, timeout_err 0, overrun_cnt 0.
REQ-037 Reset mid-transaction SHALL abandon it immediately; no out_valid after release until a new tick.

Verification
REQ-038 sample_period=3, ch_req=4'b0101, out_ready=1, buffer model 1-cycle -> grants alternate ch0,ch2; out_ch 0 then 2; out_valid 3 cycles after each tick.
REQ-039 ch_data ch1=8'hA5, only ch_req[1] -> buf_sensor_input=8'hA5 during READ, out_data=8'hA5, out_ch=1.
REQ-040 out_ready held 0 for 10 cycles, sample_period=1 -> out_data stable, overrun_cnt increments per lost tick; release -> one transfer.
REQ-041 Buffer model never asserts buf_valid, TIMEOUT=4 -> timeout_err=1 after 4 CAPTURE cycles, FSM IDLE, out_valid never 1.
REQ-042 Reset asserted during CAPTURE -> all outputs reset values same cycle (async); after release no out_valid before next tick.
REQ-043 enable dropped in READ -> transaction completes with out_valid; no further ch_grant while enable=0.

Source files
------------

// File: rtl/sensor_sample_scheduler.sv
// sensor_sample_scheduler
//
// Periodically picks one requesting sensor channel, round-robin. It pushes that
// channel's sample through a shared input buffer and presents the buffered result
// downstream with a valid/ready handshake.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   enable              permits new sampling rounds (tick generation)
//   sample_period       tick interval minus one, in cycles
//   ch_req, ch_data     per-channel level requests and packed sample data
//   ch_grant            one-hot grant, high only while reading the buffer
//   buf_read_enable     load strobe to the input buffer
//   buf_sensor_input    granted channel's data to the buffer (0 when not reading)
//   buf_output          data returned by the buffer
//   buf_valid           buffer valid flag
//   out_data, out_ch    captured sample and its channel index
//   out_valid/out_ready downstream handshake
//   timeout_err         sticky: buffer never returned valid
//   overrun_cnt         saturating count of ticks dropped while busy
module sensor_sample_scheduler #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned TIMEOUT  = 4,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [PERIOD_W-1:0]      sample_period,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_grant,
  output logic                     buf_read_enable,
  output logic [DATA_W-1:0]        buf_sensor_input,
  input  logic [DATA_W-1:0]        buf_output,
  input  logic                     buf_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     timeout_err,
  output logic [7:0]               overrun_cnt
);

  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRead, StCapture, StOut} state_e;

  state_e state_q, state_d;

  logic [PERIOD_W-1:0] count_q;
  logic                tick;
  logic [CH_W-1:0]     last_q;   // last-granted channel; also the current winner
  logic [CH_W-1:0]     win_idx;
  logic                win_found;
  logic [CH_W-1:0]     cand;
  logic [TO_W-1:0]     wait_q;
  logic                grant_load;
  logic                capture_load;
  logic                timeout_hit;

  // Tick generator
  assign tick = enable && (count_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (!enable) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= sample_period;
    end else begin
      count_q <= count_q - 1'b1;
    end
  end

  // Round-robin search, starting at the channel after the last grant
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = last_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cand == LAST_CH) begin
        cand = '0;
      end else begin
        cand = cand + 1'b1;
      end
      if (!win_found && ch_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // FSM next state
  always_comb begin
    state_d      = state_q;
    grant_load   = 1'b0;
    capture_load = 1'b0;
    timeout_hit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick && win_found) begin
          grant_load = 1'b1;
          state_d    = StRead;
        end
      end
      StRead: state_d = StCapture;
      StCapture: begin
        if (buf_valid) begin
          capture_load = 1'b1;
          state_d      = StOut;
        end else if (wait_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = StIdle;
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      last_q      <= LAST_CH;
      wait_q      <= '0;
      out_data    <= '0;
      out_ch      <= '0;
      timeout_err <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (grant_load) begin
        last_q <= win_idx;
      end
      // Counts CAPTURE cycles without valid; cleared whenever not capturing
      if (state_q != StCapture) begin
        wait_q <= '0;
      end else if (!buf_valid) begin
        wait_q <= wait_q + 1'b1;
      end
      if (capture_load) begin
        out_data <= buf_output;
        out_ch   <= last_q;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
      // A tick arriving while busy is dropped, only counted
      if (tick && (state_q != StIdle) && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  // Buffer-side outputs are decoded from state so reset clears them at once
  always_comb begin
    ch_grant         = '0;
    buf_sensor_input = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((state_q == StRead) && (last_q == CH_W'(i))) begin
        ch_grant[i]      = 1'b1;
        buf_sensor_input = ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign buf_read_enable = (state_q == StRead);
  assign out_valid       = (state_q == StOut);

endmodule
